// File: rtl/phy_rx_lane_arbiter.sv
// Merges four receive lanes into one byte stream with round-robin arbitration, gated by a link-sync FSM.
// Optional macro LANE_ERR_CNT_EN adds err_cnt, a saturating count of RUN->SYNC resynchronisation events.
module phy_rx_lane_arbiter #(
    parameter int unsigned SYNC_HOLD = 4
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [3:0]  lane_en,
    input  logic [3:0]  active,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  grant,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic [1:0]  lane_id,
    output logic [1:0]  state
`ifdef LANE_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD = 4'(SYNC_HOLD);

    state_t      r_state;
    logic [3:0]  r_syncCnt;
    logic [1:0]  r_ptr;
    logic [7:0]  r_dataOut;
    logic        r_validOut;
    logic [1:0]  r_laneId;

    logic        w_lanesOk;
    logic        w_anyEn;
    logic [3:0]  w_eligible;
    logic        w_grantEn;
    logic        w_found;
    logic        w_granting;
    logic [1:0]  w_idx;
    logic [1:0]  w_grantIdx;
    logic [3:0]  w_grant;
    logic [7:0]  w_grantByte;
    logic [3:0]  w_cntNext;

    assign w_anyEn    = (lane_en != 4'd0);
    assign w_lanesOk  = ((active & lane_en) == lane_en);
    assign w_eligible = req & lane_en & active;
    // A single enabled lane losing sync suppresses every grant in that cycle, not just its own.
    assign w_grantEn  = reset && (r_state == RUN) && w_anyEn && w_lanesOk;

    always_comb begin
        w_found    = 1'b0;
        w_idx      = r_ptr;
        w_grantIdx = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && w_eligible[w_idx]) begin
                w_found    = 1'b1;
                w_grantIdx = w_idx;
            end
        end
        w_granting = w_grantEn && w_found;
        w_grant    = 4'd0;
        if (w_granting) begin
            w_grant = 4'b0001 << w_grantIdx;
        end
    end

    assign w_grantByte = data_in[8*w_grantIdx +: 8];

    always_comb begin
        w_cntNext = 4'd0;
        if (w_lanesOk) begin
            w_cntNext = (r_syncCnt >= HOLD) ? HOLD : r_syncCnt + 4'd1;
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_syncCnt  <= 4'd0;
            r_ptr      <= 2'd0;
            r_dataOut  <= 8'h00;
            r_validOut <= 1'b0;
            r_laneId   <= 2'd0;
        end else begin
            if (w_granting) begin
                r_dataOut  <= w_grantByte;
                r_laneId   <= w_grantIdx;
                r_validOut <= 1'b1;
                r_ptr      <= w_grantIdx + 2'd1;
            end else begin
                r_dataOut  <= 8'h00;
                r_validOut <= 1'b0;
            end

            if (!w_anyEn) begin
                r_state   <= IDLE;
                r_syncCnt <= 4'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state   <= SYNC;
                        r_syncCnt <= 4'd0;
                    end
                    SYNC: begin
                        r_syncCnt <= w_cntNext;
                        if (w_lanesOk && (w_cntNext == HOLD)) begin
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!w_lanesOk) begin
                            r_state   <= SYNC;
                            r_syncCnt <= 4'd0;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_syncCnt <= 4'd0;
                    end
                endcase
            end
        end
    end

`ifdef LANE_ERR_CNT_EN
    logic [7:0] r_errCnt;

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_errCnt <= 8'd0;
        end else if ((r_state == RUN) && w_anyEn && !w_lanesOk && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    assign err_cnt = r_errCnt;
`endif

    assign grant     = w_grant;
    assign data_out  = r_dataOut;
    assign valid_out = r_validOut;
    assign lane_id   = r_laneId;
    assign state     = r_state;

endmodule

// File: doc/phy_rx_lane_arbiter.md
PHY_RX_LANE_ARBITER -- requirements
Module: phy_rx_lane_arbiter

Interface
REQ-001 SHALL have parameter SYNC_HOLD, default 4: consecutive cycles all enabled lanes must be active before RUN (range 1-15).
REQ-002 SHALL have port clk_4f  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port lane_en  input  4  static mask of lanes taking part in arbitration.
REQ-005 SHALL have port active  input  4  per-lane link-synchronised flag from the serial-to-parallel receivers.
REQ-006 SHALL have port req  input  4  per-lane request; lane i holds its byte until granted.
REQ-007 SHALL have port data_in  input  32  lane i byte on bits [8i+7:8i].
REQ-008 SHALL have port grant  output  4  combinational one-hot grant, zero when nothing is granted.
REQ-009 SHALL have port data_out  output  8  registered merged byte.
REQ-010 SHALL have port valid_out  output  1  registered qualifier for data_out.
REQ-011 SHALL have port lane_id  output  2  registered index of the lane that sourced data_out.
REQ-012 SHALL have port state  output  2  current FSM state: IDLE=0, SYNC=1, RUN=2.

Function
REQ-013 SHALL implement FSM IDLE/SYNC/RUN: IDLE->SYNC when lane_en!=0; SYNC->RUN when sync counter reaches SYNC_HOLD; RUN->SYNC when any enabled lane has active=0; any state->IDLE when lane_en==0 (highest priority).
REQ-014 SHALL use a 4-bit sync counter: +1 each SYNC cycle with (active & lane_en)==lane_en, cleared to 0 otherwise and on every SYNC entry, saturating at SYNC_HOLD.
REQ-015 SHALL define eligible = req & lane_en & active, and assert grant only in RUN.
REQ-016 SHALL grant round-robin: search lanes ptr, ptr+1, ... modulo 4, granting the first eligible lane.
REQ-017 SHALL update ptr to (granted lane + 1) mod 4 on the edge ending a granting cycle and hold ptr otherwise.
REQ-018 SHALL register data_out = granted lane byte, lane_id = granted index, valid_out=1 one cycle after grant (latency 1).
REQ-019 SHALL drive valid_out=0, data_out=0x00, lane_id held, in any cycle following a non-granting cycle.
REQ-020 SHALL give no grant in a cycle where an enabled lane drops active, even if other lanes request; the FSM moves to SYNC that edge.
REQ-021 SHALL never grant a lane with lane_en=0 or active=0, regardless of req.
REQ-022 SHALL sustain one grant per cycle when requests are continuous (throughput 1 byte/cycle).

Reset
REQ-023 SHALL on reset=0 immediately clear: state=IDLE, sync counter=0, ptr=0, data_out=0x00, valid_out=0, lane_id=0, err_cnt=0; grant=0 while reset is low.
REQ-024 SHALL, on reset asserted mid-operation, discard any in-flight byte (no valid_out pulse after reset release until a new grant).
REQ-025 SHALL resume from IDLE on the first clk_4f edge after reset rises.

Configuration
REQ-026 SHALL, with macro LANE_ERR_CNT_EN defined, add output err_cnt [7:0]: +1 per RUN->SYNC transition, saturating at 0xFF, cleared only by reset.
REQ-027 SHALL, without LANE_ERR_CNT_EN, omit the err_cnt port and counter entirely, all other behaviour identical.

Verification
REQ-028 SHALL test bring-up: lane_en=0xF, active=0xF from cycle 0 -> state IDLE, SYNC, RUN after 1+SYNC_HOLD(4) cycles; no grant before RUN.
REQ-029 SHALL test fairness: RUN, req=0xF held, data_in=0x44_33_22_11 -> grant 0001,0010,0100,1000 repeating; data_out 0x11,0x22,0x33,0x44 one cycle later, valid_out continuously 1.
REQ-030 SHALL test masking: lane_en=0x5, req=0xF -> only lanes 0,2 granted alternately; lane_id 0,2,0,2.
REQ-031 SHALL test dropout: in RUN drop active[1] for one cycle while req=0xF -> grant=0 that cycle, state=SYNC next, RUN again 4 clean cycles later, err_cnt=1 when LANE_ERR_CNT_EN defined.
REQ-032 SHALL test async reset: assert reset=0 between edges during streaming -> outputs zero without a clock edge; after release, state=IDLE and ptr restarts at lane 0.
